// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational lookup by fetch PC and
// registered updates from resolved branches, with a 2-bit direction counter per entry.
module branch_target_buffer #(
  parameter int unsigned NR_ENTRIES = 8,
  parameter int unsigned PC_OFFSET  = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic [63:0]  vpc_i,
  output logic [66:0]  branch_predict_o,
  input  logic [132:0] resolved_branch_i
);

  localparam int unsigned INDEX_BITS = $clog2(NR_ENTRIES);

  logic [63:0] upd_pc;
  logic [63:0] upd_target;
  logic        upd_mispredict;
  logic        upd_taken;
  logic        upd_lower_16;
  logic        upd_valid;
  logic        upd_clear;

  assign {upd_pc, upd_target, upd_mispredict, upd_taken,
          upd_lower_16, upd_valid, upd_clear} = resolved_branch_i;

  // The mispredict flag carries no weight in the update rule.
  logic unused_mispredict;
  assign unused_mispredict = upd_mispredict;

  logic [NR_ENTRIES-1:0] valid_q;
  logic [63:0]           pc_q     [NR_ENTRIES];
  logic [63:0]           target_q [NR_ENTRIES];
  logic [NR_ENTRIES-1:0] lower_16_q;
  logic [1:0]            cnt_q    [NR_ENTRIES];

  logic [INDEX_BITS-1:0] lu_idx;
  logic [INDEX_BITS-1:0] up_idx;
  logic                  lu_hit;
  logic                  up_hit;

  assign lu_idx = vpc_i[PC_OFFSET +: INDEX_BITS];
  assign up_idx = upd_pc[PC_OFFSET +: INDEX_BITS];
  assign lu_hit = valid_q[lu_idx] && (pc_q[lu_idx] == vpc_i);
  assign up_hit = valid_q[up_idx] && (pc_q[up_idx] == upd_pc);

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // Lookup: reads the stored state only, so a same-cycle update is not visible.
  always_comb begin
    branch_predict_o = '0;
    if (lu_hit) begin
      branch_predict_o = {target_q[lu_idx], cnt_q[lu_idx][1], lower_16_q[lu_idx], 1'b1};
    end
  end

  // Update: flush beats any update; clear beats the normal write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= '0;
      lower_16_q <= '0;
      for (int i = 0; i < int'(NR_ENTRIES); i++) begin
        pc_q[i]     <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= 2'b01;
      end
    end else if (flush_i) begin
      valid_q <= '0;
      for (int i = 0; i < int'(NR_ENTRIES); i++) begin
        cnt_q[i] <= 2'b01;
      end
    end else if (upd_valid) begin
      if (upd_clear) begin
        valid_q[up_idx] <= 1'b0;
        cnt_q[up_idx]   <= 2'b01;
      end else if (up_hit) begin
        cnt_q[up_idx]      <= upd_taken ? sat_inc(cnt_q[up_idx]) : sat_dec(cnt_q[up_idx]);
        target_q[up_idx]   <= upd_target;
        lower_16_q[up_idx] <= upd_lower_16;
      end else begin
        valid_q[up_idx]    <= 1'b1;
        pc_q[up_idx]       <= upd_pc;
        target_q[up_idx]   <= upd_target;
        lower_16_q[up_idx] <= upd_lower_16;
        cnt_q[up_idx]      <= upd_taken ? 2'b10 : 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Testbench for branch_target_buffer: directed scenarios plus randomized traffic
// checked against a per-index table model of the buffer.
module tb_branch_target_buffer;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic [63:0]  vpc;
  logic [66:0]  bp;
  logic [132:0] rb;

  int tests = 0;
  int fails = 0;
  logic [66:0] exp_bp;

  always #5 clk = ~clk;

  branch_target_buffer dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .flush_i           (flush),
    .vpc_i             (vpc),
    .branch_predict_o  (bp),
    .resolved_branch_i (rb)
  );

  // Reference model: one record per slot, slot chosen by word address modulo N.
  bit          m_valid [N];
  logic [63:0] m_pc    [N];
  logic [63:0] m_tgt   [N];
  bit          m_l16   [N];
  int          m_cnt   [N];

  function automatic int slot_of(input logic [63:0] pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic logic [66:0] model_lookup(input logic [63:0] pc);
    int s;
    s = slot_of(pc);
    if (m_valid[s] && m_pc[s] == pc)
      return {m_tgt[s], (m_cnt[s] >= 2) ? 1'b1 : 1'b0, m_l16[s] ? 1'b1 : 1'b0, 1'b1};
    return '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_pc[i] = '0; m_tgt[i] = '0; m_l16[i] = 0; m_cnt[i] = 1;
    end
  endtask

  task automatic model_commit();
    logic [63:0] pc;
    int s;
    pc = rb[132:69];
    s  = slot_of(pc);
    if (flush) begin
      for (int i = 0; i < N; i++) begin m_valid[i] = 0; m_cnt[i] = 1; end
    end else if (rb[1]) begin
      if (rb[0]) begin
        m_valid[s] = 0; m_cnt[s] = 1;
      end else if (m_valid[s] && m_pc[s] == pc) begin
        m_cnt[s] = rb[3] ? ((m_cnt[s] + 1 > 3) ? 3 : m_cnt[s] + 1)
                         : ((m_cnt[s] - 1 < 0) ? 0 : m_cnt[s] - 1);
        m_tgt[s] = rb[68:5];
        m_l16[s] = rb[2];
      end else begin
        m_valid[s] = 1; m_pc[s] = pc; m_tgt[s] = rb[68:5];
        m_l16[s] = rb[2]; m_cnt[s] = rb[3] ? 2 : 1;
      end
    end
  endtask

  task automatic set_update(input logic [63:0] pc, input logic [63:0] tgt, input bit taken,
                            input bit l16, input bit clr, input bit mp);
    rb = {pc, tgt, mp, taken, l16, 1'b1, clr};
  endtask

  task automatic idle();
    rb    = '0;
    flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); vpc = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    vpc = 64'h8000_0000; #1;
    tests++;
    if (bp !== 67'h0) begin
      fails++; $display("FAIL reset_lookup: got %h, expected %h", bp, 67'h0);
    end
  endtask

  task automatic test_update_hit();
    set_update(64'h8000_0010, 64'h8000_0100, 1, 1, 0, 0);
    tick(); idle();
    vpc = 64'h8000_0010; #1;
    exp_bp = {64'h8000_0100, 1'b1, 1'b1, 1'b1};
    tests++;
    if (bp !== exp_bp) begin
      fails++; $display("FAIL first_hit: got %h, expected %h", bp, exp_bp);
    end
    vpc = 64'h8000_0030; #1;
    tests++;
    if (bp !== 67'h0) begin
      fails++; $display("FAIL same_index_other_pc: got %h, expected %h", bp, 67'h0);
    end
  endtask

  task automatic test_saturation();
    bit seq_taken [10] = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
    bit seq_pred  [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
    for (int k = 0; k < 10; k++) begin
      set_update(64'h8000_0010, 64'h8000_0100, seq_taken[k], 1, 0, seq_taken[k]);
      tick(); idle();
      vpc = 64'h8000_0010; #1;
      exp_bp = {64'h8000_0100, seq_pred[k] ? 1'b1 : 1'b0, 1'b1, 1'b1};
      tests++;
      if (bp !== exp_bp) begin
        fails++; $display("FAIL saturation step %0d: got %h, expected %h", k, bp, exp_bp);
      end
    end
  endtask

  task automatic test_clear_flush();
    set_update(64'h8000_0010, 64'h0, 0, 0, 1, 0);
    tick(); idle();
    vpc = 64'h8000_0010; #1;
    tests++;
    if (bp !== 67'h0) begin
      fails++; $display("FAIL clear_entry: got %h, expected %h", bp, 67'h0);
    end
    for (int i = 0; i < N; i++) begin
      set_update(64'h2000 + 64'(i) * 4, 64'h9000 + 64'(i), i[0], 0, 0, 0);
      tick();
    end
    idle();
    for (int i = 0; i < N; i++) begin
      vpc = 64'h2000 + 64'(i) * 4; #1;
      exp_bp = {64'h9000 + 64'(i), i[0], 1'b0, 1'b1};
      tests++;
      if (bp !== exp_bp) begin
        fails++; $display("FAIL fill slot %0d: got %h, expected %h", i, bp, exp_bp);
      end
    end
    flush = 1'b1;
    tick(); idle();
    for (int i = 0; i < N; i++) begin
      vpc = 64'h2000 + 64'(i) * 4; #1;
      tests++;
      if (bp !== 67'h0) begin
        fails++; $display("FAIL after_flush slot %0d: got %h, expected %h", i, bp, 67'h0);
      end
    end
    flush = 1'b1;
    set_update(64'h3000, 64'h3333, 1, 0, 0, 0);
    tick(); idle();
    vpc = 64'h3000; #1;
    tests++;
    if (bp !== 67'h0) begin
      fails++; $display("FAIL flush_drops_update: got %h, expected %h", bp, 67'h0);
    end
  endtask

  task automatic test_read_during_write();
    set_update(64'h8000_0040, 64'h8000_0400, 0, 0, 0, 1);
    vpc = 64'h8000_0040; #1;
    tests++;
    if (bp !== 67'h0) begin
      fails++; $display("FAIL rdw_same_cycle: got %h, expected %h", bp, 67'h0);
    end
    tick(); idle(); #1;
    exp_bp = {64'h8000_0400, 1'b0, 1'b0, 1'b1};
    tests++;
    if (bp !== exp_bp) begin
      fails++; $display("FAIL rdw_next_cycle: got %h, expected %h", bp, exp_bp);
    end
  endtask

  task automatic test_alias();
    set_update(64'h1000, 64'h1111, 1, 0, 0, 0);
    tick();
    set_update(64'h1020, 64'h2222, 0, 1, 0, 0);
    tick(); idle();
    vpc = 64'h1000; #1;
    tests++;
    if (bp !== 67'h0) begin
      fails++; $display("FAIL alias_evicted: got %h, expected %h", bp, 67'h0);
    end
    vpc = 64'h1020; #1;
    exp_bp = {64'h2222, 1'b0, 1'b1, 1'b1};
    tests++;
    if (bp !== exp_bp) begin
      fails++; $display("FAIL alias_new: got %h, expected %h", bp, exp_bp);
    end
  endtask

  task automatic test_reset_mid();
    set_update(64'h5008, 64'h5555, 1, 1, 0, 0);
    tick(); idle();
    vpc = 64'h5008; #2;
    rst_n = 1'b0; #1;
    model_reset();
    tests++;
    if (bp !== 67'h0) begin
      fails++; $display("FAIL async_reset: got %h, expected %h", bp, 67'h0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    set_update(64'h5008, 64'h6666, 0, 0, 0, 0);
    tick(); idle(); #1;
    exp_bp = {64'h6666, 1'b0, 1'b0, 1'b1};
    tests++;
    if (bp !== exp_bp) begin
      fails++; $display("FAIL update_after_reset: got %h, expected %h", bp, exp_bp);
    end
  endtask

  task automatic test_random();
    logic [63:0] pc;
    logic [63:0] tgt;
    for (int n = 0; n < 400; n++) begin
      pc  = 64'h4000 + 64'($urandom_range(0, 15)) * 4;
      tgt = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0)
        set_update(pc, tgt, 1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0, 1'($urandom));
      else
        rb = '0;
      flush = ($urandom_range(0, 15) == 0);
      vpc   = 64'h4000 + 64'($urandom_range(0, 15)) * 4;
      #1;
      exp_bp = model_lookup(vpc);
      tests++;
      if (bp !== exp_bp) begin
        fails++; $display("FAIL random iter %0d vpc %h: got %h, expected %h", n, vpc, bp, exp_bp);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_update_hit();
    test_saturation();
    test_clear_flush();
    test_read_during_write();
    test_alias();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Direct-mapped branch target buffer.
- Consumes resolved-branch updates (`branchpredict`) from the EX stage.
- Produces per-PC prediction hints (`branchpredict_sbe`) for the fetch stage, which carries them in `fetch_entry.branch_predict`.
- Each entry holds the branch PC, target, a compressed-slot flag and a 2-bit saturating direction counter.

Parameters:
- NR_ENTRIES, 8: number of BTB entries; power of two, ≥2.
- INDEX_BITS, $clog2(NR_ENTRIES): derived, not overridable.
- PC_OFFSET, 2: lowest PC bit used for indexing (word-granular).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- flush_i  in  1  invalidate all entries on the next edge
- vpc_i  in  64  fetch PC to look up
- branch_predict_o  out  67  `branchpredict_sbe`: {predict_address, predict_taken, is_lower_16, valid}
- resolved_branch_i  in  133  `branchpredict`: {pc, target_address, is_mispredict, is_taken, is_lower_16, valid, clear}

Behaviour:
- Indexing:
  - Lookup index = vpc_i[PC_OFFSET+INDEX_BITS-1:PC_OFFSET].
  - Update index = resolved_branch_i.pc, same bits.
- Entry state: valid, pc[63:0], target[63:0], is_lower_16, cnt[1:0].
- Reset (rst_ni=0, asynchronous): all valid=0, cnt=2'b01, pc/target=0. branch_predict_o is then all-zero, since lookup of an invalid entry yields zero.
- Lookup, combinational, zero latency:
  - hit = entry.valid && entry.pc == vpc_i (full 64-bit compare).
  - On hit: valid=1, predict_taken=cnt[1], predict_address=target, is_lower_16=entry.is_lower_16.
  - On miss: all fields 0.
- Update, registered, takes effect at the edge after resolved_branch_i.valid=1:
  - clear=1: entry valid←0, cnt←2'b01. Other fields don't care. Clear overrides the normal write.
  - clear=0 and entry hit on resolved pc (valid && pc equal):
    - is_taken=1: cnt saturating increment, max 2'b11.
    - is_taken=0: cnt saturating decrement, min 2'b00.
    - target←target_address, is_lower_16 updated.
  - clear=0 and miss (invalid or different pc): allocate/replace. valid←1, pc←resolved pc, target←target_address, is_lower_16←is_lower_16, cnt←is_taken ? 2'b10 : 2'b01.
  - is_mispredict is informational only; it does not change the update rule.
- Read-during-write: a lookup in the same cycle as an update to that index returns the pre-update contents. No bypass.
- flush_i=1: all valid←0 and cnt←2'b01 at the edge. flush_i has priority over a simultaneous update, and the update is dropped.
- Aliasing: two PCs sharing an index evict each other. This is not an error.
- Only the indexed entry changes per cycle; at most one update per cycle.
- Reset asserted mid-operation clears state immediately. The first update after reset deassertion is accepted normally.

Test Plan:
- Reset, then vpc_i=0x8000_0000 → branch_predict_o == 0.
- Update pc=0x8000_0010, target=0x8000_0100, is_taken=1, is_lower_16=1, valid=1. Next cycle vpc_i=0x8000_0010 → valid=1, predict_taken=1, predict_address=0x8000_0100, is_lower_16=1. vpc_i=0x8000_0030 (same index, different pc) → valid=0.
- Saturation: same pc with 3 more taken updates → cnt=3, predict_taken=1. Then 2 not-taken → cnt=1, predict_taken=0. Then 3 more not-taken → cnt=0. Then 1 taken → cnt=1, still not taken.
- Clear/flush: update with clear=1 on pc 0x8000_0010 → next lookup valid=0. Fill indices 0..7, then pulse flush_i → all lookups miss. flush_i together with an update in the same cycle → the entry remains invalid.
- Read-during-write: lookup 0x8000_0040 in the same cycle as the first update for it → miss that cycle, hit the following cycle.
- Alias replace: pc A=0x1000 taken, then pc B=0x1020 not-taken (same index) → A misses; B hits with predict_taken=0 (cnt=2'b01).
